// File: rtl/pipe_hazard_ctrl.sv
// Hazard and flush sequencer for the 5-stage core: drives the PC, IF/ID and ID/EX
// enables from load-use, branch, fetch-ready and data-memory-busy conditions.
//
// state    | meaning
// ---------+----------------------------------------------------------
// RUN      | normal issue; load-use, branch and fetch stalls decided here
// FLUSH    | squashing wrong-path fetches after a taken branch
// MEM_WAIT | whole pipeline frozen on dmem_busy; RUN rules apply on release
module pipe_hazard_ctrl #(
  parameter int REG_W        = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             pc_redirect,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_t           state_q, state_nxt;
  logic [2:0]       flush_left_q, flush_left_nxt;
  logic             lu_hazard;

  assign lu_hazard = ex_memread && (ex_rd != '0) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    pc_write       = 1'b1;
    pc_redirect    = 1'b0;
    ifid_write     = 1'b1;
    ifid_flush     = 1'b0;
    idex_bubble    = 1'b0;
    state_nxt      = state_q;
    flush_left_nxt = flush_left_q;

    if (rst) begin
      // Hold the front end in a safe NOP-injecting state while reset is high.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_nxt   = ST_RUN;
    end else if (dmem_busy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      state_nxt  = (state_q == ST_FLUSH) ? ST_FLUSH : ST_MEM_WAIT;
    end else if (state_q == ST_FLUSH) begin
      // EX holds a bubble here, so branch and load-use inputs are meaningless.
      pc_write       = imem_ready;
      ifid_flush     = 1'b1;
      idex_bubble    = 1'b1;
      flush_left_nxt = flush_left_q - 3'd1;
      if (flush_left_q <= 3'd1) state_nxt = ST_RUN;
    end else begin
      state_nxt = ST_RUN;
      if (ex_branch_taken) begin
        pc_redirect = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_nxt      = ST_FLUSH;
          flush_left_nxt = FLUSH_INIT;
        end
      end else if (lu_hazard) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end else if (!imem_ready) begin
        pc_write   = 1'b0;
        ifid_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      flush_left_q <= 3'd0;
    end else begin
      state_q      <= state_nxt;
      flush_left_q <= flush_left_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!pc_write && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
      if (ifid_flush && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (default and CNT_W=2/FLUSH_CYCLES=3)
// compared every cycle against an event-level reference model.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_memread, ex_branch_taken, imem_ready, dmem_busy;

  logic        pcw_a, red_a, ifw_a, ifl_a, bub_a;
  logic [1:0]  st_a;
  logic [15:0] sc_a, fc_a;
  logic        pcw_b, red_b, ifw_b, ifl_b, bub_b;
  logic [1:0]  st_b;
  logic [1:0]  sc_b, fc_b;

  int total = 0;
  int bad   = 0;

  int fcyc[2] = '{2, 3};
  int cmax[2] = '{65535, 3};
  int mode[2];     // 0 run, 1 flushing, 2 waiting on memory
  int left[2];     // flush cycles still owed after the current one
  int stalls[2];
  int flushes[2];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_W(5), .FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready),
    .dmem_busy(dmem_busy), .pc_write(pcw_a), .pc_redirect(red_a), .ifid_write(ifw_a),
    .ifid_flush(ifl_a), .idex_bubble(bub_a), .state(st_a), .stall_count(sc_a),
    .flush_count(fc_a));

  pipe_hazard_ctrl #(.REG_W(5), .FLUSH_CYCLES(3), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready),
    .dmem_busy(dmem_busy), .pc_write(pcw_b), .pc_redirect(red_b), .ifid_write(ifw_b),
    .ifid_flush(ifl_b), .idex_bubble(bub_b), .state(st_b), .stall_count(sc_b),
    .flush_count(fc_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected controls {pc_write, pc_redirect, ifid_write, ifid_flush, idex_bubble}
  task automatic model_eval(input int k, output logic [4:0] ctl, output int nm, output int nl);
    bit lu;
    lu = ex_memread && ex_rd != 0 &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    nm = mode[k];
    nl = left[k];
    if (rst) begin
      ctl = 5'b00011; nm = 0; nl = 0;
    end else if (dmem_busy) begin
      ctl = 5'b00000; nm = (mode[k] == 1) ? 1 : 2;
    end else if (mode[k] == 1) begin
      ctl = {imem_ready, 4'b0111};
      nl = left[k] - 1;
      nm = (nl == 0) ? 0 : 1;
    end else if (ex_branch_taken) begin
      ctl = 5'b11111;
      nm = (fcyc[k] > 1) ? 1 : 0;
      nl = fcyc[k] - 1;
    end else if (lu) begin
      ctl = 5'b00001; nm = 0;
    end else if (!imem_ready) begin
      ctl = 5'b00110; nm = 0;
    end else begin
      ctl = 5'b10100; nm = 0;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mode[k] = 0; left[k] = 0; stalls[k] = 0; flushes[k] = 0;
    end
  endtask

  task automatic cycle();
    logic [4:0] e[2];
    int nm[2], nl[2];
    @(negedge clk);
    for (int k = 0; k < 2; k++) model_eval(k, e[k], nm[k], nl[k]);
    check("ctl_a",   {pcw_a, red_a, ifw_a, ifl_a, bub_a}, e[0]);
    check("state_a", st_a, mode[0]);
    check("stall_a", sc_a, stalls[0]);
    check("flush_a", fc_a, flushes[0]);
    check("ctl_b",   {pcw_b, red_b, ifw_b, ifl_b, bub_b}, e[1]);
    check("state_b", st_b, mode[1]);
    check("stall_b", sc_b, stalls[1]);
    check("flush_b", fc_b, flushes[1]);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mode[k] = 0; left[k] = 0; stalls[k] = 0; flushes[k] = 0;
      end else begin
        mode[k] = nm[k];
        left[k] = nl[k];
        if (!e[k][4] && stalls[k] < cmax[k]) stalls[k]++;
        if (e[k][1] && flushes[k] < cmax[k]) flushes[k]++;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_memread = 0;
    ex_branch_taken = 0; imem_ready = 1; dmem_busy = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;

    // load-use on rs2, then the same with ex_rd = x0
    ex_memread = 1; ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1;
    cycle();
    idle_inputs();
    cycle();
    check("lu_stall_count", sc_a, 16'd1);
    ex_memread = 1; ex_rd = 0; id_rs2 = 0; id_uses_rs2 = 1;
    cycle();
    idle_inputs();
    check("x0_no_stall", sc_a, 16'd1);

    // taken branch
    ex_branch_taken = 1;
    cycle();
    ex_branch_taken = 0;
    cycle();
    cycle();
    check("branch_flush_count", fc_a, 16'd2);

    // freeze in the middle of a flush
    ex_branch_taken = 1;
    cycle();
    ex_branch_taken = 0;
    dmem_busy = 1;
    repeat (3) cycle();
    dmem_busy = 0;
    cycle();
    cycle();
    check("freeze_flush_count", fc_a, 16'd4);
    check("freeze_stall_count", sc_a, 16'd4);

    // busy with a held branch, redirect on release
    dmem_busy = 1; ex_branch_taken = 1;
    repeat (4) cycle();
    dmem_busy = 0;
    cycle();
    ex_branch_taken = 0;
    cycle();
    cycle();
    check("busy_branch_stalls", sc_a, 16'd8);

    // fetch not ready
    imem_ready = 0;
    repeat (3) cycle();
    imem_ready = 1;
    cycle();

    // asynchronous reset in the middle of a flush
    ex_branch_taken = 1;
    cycle();
    ex_branch_taken = 0;
    check("in_flush_before_rst", st_a, 32'd1);
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_state", st_a, 32'd0);
    check("async_rst_ctl", {pcw_a, red_a, ifw_a, ifl_a, bub_a}, 5'b00011);
    check("async_rst_stall", sc_a, 16'd0);
    cycle();
    rst = 1'b0;
    cycle();

    // saturation of the narrow counter
    imem_ready = 0;
    repeat (5) cycle();
    imem_ready = 1;
    check("stall_saturate", sc_b, 2'd3);
    cycle();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      ex_rd           = 5'($urandom_range(0, 3));
      id_uses_rs1     = 1'($urandom_range(0, 1));
      id_uses_rs2     = 1'($urandom_range(0, 1));
      ex_memread      = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      imem_ready      = ($urandom_range(0, 4) != 0);
      dmem_busy       = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      cycle();
    end
    rst = 1'b0;
    idle_inputs();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
